// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard constants, transmitter state type and frame helpers
// used by the ASCII-to-PS/2 transmit path.
package ps2_pkg;

  localparam logic [7:0] KB_BREAK  = 8'hF0;
  localparam logic [7:0] KB_LSHIFT = 8'h12;
  localparam int         PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    GAP
  } tx_state_t;

  // Byte idx of the make/break sequence for one key, with optional left-shift wrap.
  function automatic logic [7:0] seq_byte(input logic shift, input logic [7:0] code,
                                          input logic [2:0] idx);
    logic [7:0] b;
    b = code;
    if (!shift) begin
      case (idx)
        3'd1:    b = KB_BREAK;
        default: b = code;
      endcase
    end else begin
      case (idx)
        3'd0:    b = KB_LSHIFT;
        3'd1:    b = code;
        3'd2:    b = KB_BREAK;
        3'd3:    b = code;
        3'd4:    b = KB_BREAK;
        default: b = KB_LSHIFT;
      endcase
    end
    return b;
  endfunction

  // Frame in transmit order from bit 0: start, d0..d7, odd parity, stop.
  function automatic logic [PS2_FRAME_BITS-1:0] build_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

endpackage

// File: rtl/ascii2kbcode.sv
// Combinational ASCII to PS/2 Set 2 make-code lookup; uppercase letters reuse
// the lowercase code and request a left-shift wrap.
module ascii2kbcode
  import ps2_pkg::*;
(
  input  logic [7:0] ascii,
  output logic       mapped,
  output logic       shift,
  output logic [7:0] code
);

  logic [7:0] key;

  always_comb begin
    shift  = (ascii >= 8'h41) && (ascii <= 8'h5A);
    key    = shift ? (ascii | 8'h20) : ascii;
    mapped = 1'b1;
    code   = 8'h00;
    case (key)
      8'h61: code = 8'h1C;
      8'h62: code = 8'h32;
      8'h63: code = 8'h21;
      8'h64: code = 8'h23;
      8'h65: code = 8'h24;
      8'h66: code = 8'h2B;
      8'h67: code = 8'h34;
      8'h68: code = 8'h33;
      8'h69: code = 8'h43;
      8'h6A: code = 8'h3B;
      8'h6B: code = 8'h42;
      8'h6C: code = 8'h4B;
      8'h6D: code = 8'h3A;
      8'h6E: code = 8'h31;
      8'h6F: code = 8'h44;
      8'h70: code = 8'h4D;
      8'h71: code = 8'h15;
      8'h72: code = 8'h2D;
      8'h73: code = 8'h1B;
      8'h74: code = 8'h2C;
      8'h75: code = 8'h3C;
      8'h76: code = 8'h2A;
      8'h77: code = 8'h1D;
      8'h78: code = 8'h22;
      8'h79: code = 8'h35;
      8'h7A: code = 8'h1A;
      8'h30: code = 8'h45;
      8'h31: code = 8'h16;
      8'h32: code = 8'h1E;
      8'h33: code = 8'h26;
      8'h34: code = 8'h25;
      8'h35: code = 8'h2E;
      8'h36: code = 8'h36;
      8'h37: code = 8'h3D;
      8'h38: code = 8'h3E;
      8'h39: code = 8'h46;
      8'h20: code = 8'h29;
      8'h0D: code = 8'h5A;
      8'h08: code = 8'h66;
      default: begin
        mapped = 1'b0;
        code   = 8'h00;
      end
    endcase
  end

endmodule

// File: rtl/ascii2ps2_tx.sv
// Keyboard-side PS/2 transmitter: takes one ASCII character per handshake and
// sends its make/break scan-code sequence as device-to-host frames.
module ascii2ps2_tx
  import ps2_pkg::*;
#(
  parameter int HALF_PERIOD = 4000,
  parameter int GAP_CYCLES  = 8000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ascii,
  input  logic       valid,
  output logic       ready,
  output logic       done,
  output logic       err,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam int SLOT_CYCLES = 2 * HALF_PERIOD;
  localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [SLOT_W-1:0] CLK_FALL  = SLOT_W'(HALF_PERIOD - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]        LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

  tx_state_t                  state;
  logic [SLOT_W-1:0]          slot_cnt;
  logic [GAP_W-1:0]           gap_cnt;
  logic [3:0]                 bit_idx;
  logic [2:0]                 byte_idx;
  logic                       shift_q;
  logic [7:0]                 code_q;
  logic [PS2_FRAME_BITS-1:0]  frame;

  logic                       map_ok;
  logic                       map_shift;
  logic [7:0]                 map_code;
  logic [PS2_FRAME_BITS-1:0]  load_frame;
  logic [2:0]                 last_byte;

  ascii2kbcode u_map (
    .ascii  (ascii),
    .mapped (map_ok),
    .shift  (map_shift),
    .code   (map_code)
  );

  assign load_frame = build_frame(seq_byte(shift_q, code_q, byte_idx));
  assign last_byte  = shift_q ? 3'd5 : 3'd2;

  // The frame register shifts right so the next slot's bit is always frame[1].
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ready    <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      slot_cnt <= '0;
      gap_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shift_q  <= 1'b0;
      code_q   <= '0;
      frame    <= '1;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (valid && ready) begin
            ready <= 1'b0;
            if (map_ok) begin
              shift_q  <= map_shift;
              code_q   <= map_code;
              byte_idx <= '0;
              state    <= LOAD;
            end else begin
              err <= 1'b1;
            end
          end else begin
            ready <= 1'b1;
          end
        end

        LOAD: begin
          frame    <= load_frame;
          ps2_data <= load_frame[0];
          ps2_clk  <= 1'b1;
          slot_cnt <= '0;
          bit_idx  <= '0;
          state    <= SEND;
        end

        SEND: begin
          if (slot_cnt == SLOT_LAST) begin
            slot_cnt <= '0;
            ps2_clk  <= 1'b1;
            if (bit_idx == LAST_BIT) begin
              ps2_data <= 1'b1;
              bit_idx  <= '0;
              gap_cnt  <= '0;
              state    <= GAP;
            end else begin
              bit_idx  <= bit_idx + 4'd1;
              ps2_data <= frame[1];
              frame    <= {1'b1, frame[PS2_FRAME_BITS-1:1]};
            end
          end else begin
            slot_cnt <= slot_cnt + 1'b1;
            if (slot_cnt == CLK_FALL) begin
              ps2_clk <= 1'b0;
            end
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            if (byte_idx != last_byte) begin
              byte_idx <= byte_idx + 3'd1;
              state    <= LOAD;
            end else begin
              byte_idx <= '0;
              done     <= 1'b1;
              ready    <= 1'b1;
              state    <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
